// File: rtl/cpu_pkg.sv
// Shared opcode, ALU and state definitions for the accumulator CPU control path.
package cpu_pkg;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MUL    = 8'h08;
  localparam logic [7:0] OP_SHL    = 8'h0E;

  localparam int unsigned ALU_W = 3;
  localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;
  localparam logic [ALU_W-1:0] ALU_SHL  = 3'd3;
  localparam logic [ALU_W-1:0] ALU_MUL  = 3'd4;

  typedef enum logic [2:0] {
    FETCH, DECODE, OPERAND, EXEC, MULWAIT, WRITE, HALT
  } state_t;

  // Instruction class as seen by the sequencer.
  typedef struct packed {
    logic             needs_operand;
    logic             is_write;
    logic             is_jump;
    logic             is_halt;
    logic             is_mul;
    logic             is_exec;
    logic [ALU_W-1:0] alu_op;
  } op_class_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Opcode classifier: maps IR[15:8] to the sequencing class and ALU operation.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls        = '0;
    cls.alu_op = ALU_PASS;
    case (opcode)
      OP_STORE:  cls.is_write = 1'b1;
      OP_LOAD:   cls.needs_operand = 1'b1;
      OP_ADD: begin
        cls.needs_operand = 1'b1;
        cls.alu_op        = ALU_ADD;
      end
      OP_SUB: begin
        cls.needs_operand = 1'b1;
        cls.alu_op        = ALU_SUB;
      end
      OP_MUL: begin
        cls.needs_operand = 1'b1;
        cls.is_mul        = 1'b1;
        cls.alu_op        = ALU_MUL;
      end
      OP_SHL: begin
        cls.is_exec = 1'b1;
        cls.alu_op  = ALU_SHL;
      end
      OP_JMPGEZ: cls.is_jump = 1'b1;
      OP_HALT:   cls.is_halt = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Moore control sequencer for the accumulator CPU (fetch/decode/operand/exec/write).
// Optional macro SINGLE_STEP_EN adds a Step input that gates each instruction fetch.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       DATA_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int unsigned       MUL_MAX_WAIT = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] Mem_Dout,
  input  logic [DATA_W-1:0] Acc,
  input  logic              Mul_Done,
`ifdef SINGLE_STEP_EN
  input  logic              Step,
`endif
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_R_W,
  output logic [2:0]        Alu_Op,
  output logic              Acc_Ld,
  output logic              Mul_Start,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic              Halted,
  output logic              Err
);

  localparam int unsigned CNT_W = (MUL_MAX_WAIT > 2) ? $clog2(MUL_MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_MAX_WAIT - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [CNT_W-1:0]  cnt;
  logic              err;
  op_class_t         cls;
  logic              step_ok;
  logic              unused_acc;

  wire [ADDR_W-1:0] opnd_addr = ir[ADDR_W-1:0];

  // Only the sign bit of the accumulator steers control.
  assign unused_acc = ^Acc[DATA_W-2:0];

`ifdef SINGLE_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  cpu_ctrl_decode u_dec (
    .opcode (ir[DATA_W-1 -: 8]),
    .cls    (cls)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        FETCH: if (step_ok) begin
          ir    <= Mem_Dout;
          pc    <= pc + ADDR_W'(1);
          state <= DECODE;
        end
        DECODE: begin
          if (cls.is_halt)            state <= HALT;
          else if (cls.is_write)      state <= WRITE;
          else if (cls.needs_operand) state <= OPERAND;
          else if (cls.is_exec)       state <= EXEC;
          else begin
            if (cls.is_jump && !Acc[DATA_W-1]) pc <= opnd_addr;
            state <= FETCH;
          end
        end
        OPERAND: begin
          cnt   <= '0;
          state <= cls.is_mul ? MULWAIT : EXEC;
        end
        EXEC:  state <= FETCH;
        WRITE: state <= FETCH;
        MULWAIT: begin
          if (Mul_Done) state <= FETCH;
          else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= HALT;
          end else cnt <= cnt + CNT_W'(1);
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Output decode of registered state; the single input dependency is Acc_Ld
  // tracking Mul_Done in MULWAIT so the product is captured on the done cycle.
  always_comb begin
    Mem_Addr  = pc;
    Mem_R_W   = 1'b0;
    Alu_Op    = ALU_PASS;
    Acc_Ld    = 1'b0;
    Mul_Start = 1'b0;
    case (state)
      DECODE:  Mem_Addr = opnd_addr;
      OPERAND: begin
        Mem_Addr  = opnd_addr;
        Mul_Start = cls.is_mul;
      end
      EXEC: begin
        Mem_Addr = opnd_addr;
        Acc_Ld   = 1'b1;
        Alu_Op   = cls.alu_op;
      end
      MULWAIT: begin
        Mem_Addr = opnd_addr;
        Alu_Op   = ALU_MUL;
        Acc_Ld   = Mul_Done;
      end
      WRITE: begin
        Mem_Addr = opnd_addr;
        Mem_R_W  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PC     = pc;
  assign IR     = ir;
  assign Halted = (state == HALT);
  assign Err    = err;

endmodule
